// File: rtl/mp_pipe_usb4_pkg.sv
// Shared encodings for the USB4 PIPE power/rate sequencer.
// FSM states, PowerDown codes and default timing constants.
package mp_pipe_usb4_pkg;

  localparam logic [2:0] ST_INIT      = 3'd0;
  localparam logic [2:0] ST_IDLE      = 3'd1;
  localparam logic [2:0] ST_PWR_REQ   = 3'd2;
  localparam logic [2:0] ST_RATE_REQ  = 3'd3;
  localparam logic [2:0] ST_PCLK_WAIT = 3'd4;
  localparam logic [2:0] ST_GAP       = 3'd5;

  localparam logic [3:0] PD_P0 = 4'd0;
  localparam logic [3:0] PD_P1 = 4'd1;
  localparam logic [3:0] PD_P2 = 4'd2;
  localparam logic [3:0] PD_P3 = 4'd3;

  localparam int DEF_MIN_GAP = 4;
  localparam int DEF_TMO_CYC = 1024;

  function automatic int cnt_w(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/mp_seq_down_cnt.sv
// Loadable down-counter with zero flag; holds at zero.
// Shared by the GAP spacing and the ack timeout.
module mp_seq_down_cnt #(
  parameter int W = 4
) (
  input  logic         pipe_clk,
  input  logic         pipe_rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] cnt,
  output logic         zero
);

  assign zero = (cnt == '0);

  always_ff @(posedge pipe_clk or negedge pipe_rst_n) begin
    if (!pipe_rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (!zero) begin
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/mp_pwr_rate_seq_usb4.sv
// PIPE PowerDown/Rate change sequencer for one USB4 lane.
// Optional ack timeout: define MP_PWR_SEQ_TIMEOUT_EN.
module mp_pwr_rate_seq_usb4
  import mp_pipe_usb4_pkg::*;
#(
  parameter int                RATE_W  = 2,
  parameter logic [3:0]        RST_PWR = PD_P2,
  parameter logic [RATE_W-1:0] RST_RATE = '0,
  parameter int                MIN_GAP = DEF_MIN_GAP,
  parameter int                TMO_CYC = DEF_TMO_CYC
) (
  input  logic              pipe_clk,
  input  logic              pipe_rst_n,
  input  logic              lane_startup_done,
  input  logic [3:0]        pipe_powerdown,
  input  logic [RATE_W-1:0] pipe_rate,
  input  logic              pma_ack,
  input  logic              pclk_change_ack,
  output logic              pma_req,
  output logic [3:0]        pma_pwr_state,
  output logic [RATE_W-1:0] pma_rate,
  output logic              pclk_change_ok,
  output logic              pwr_chg_done,
  output logic              busy,
  output logic              timeout_err
);

  localparam int CW = cnt_w(MIN_GAP, TMO_CYC);
  localparam logic [CW-1:0] GAP_LD = CW'(MIN_GAP - 1);

  logic [2:0]        state, state_nx;
  logic              req_nx, ok_nx, done_nx, err_nx;
  logic [3:0]        pwr_nx;
  logic [RATE_W-1:0] rate_nx;
  logic              cnt_ld, cnt_zero, tmo_hit;
  logic [CW-1:0]     cnt_val, cnt;

`ifdef MP_PWR_SEQ_TIMEOUT_EN
  localparam logic [CW-1:0] TMO_LD = CW'(TMO_CYC - 1);
  assign cnt_ld  = (state_nx != state);
  assign cnt_val = (state_nx == ST_GAP) ? GAP_LD : TMO_LD;
  assign tmo_hit = cnt_zero;
`else
  assign cnt_ld  = (state_nx == ST_GAP) && (state != ST_GAP);
  assign cnt_val = GAP_LD;
  assign tmo_hit = 1'b0;
`endif

  mp_seq_down_cnt #(.W(CW)) u_cnt (
    .pipe_clk   (pipe_clk),
    .pipe_rst_n (pipe_rst_n),
    .load       (cnt_ld),
    .load_val   (cnt_val),
    .cnt        (cnt),
    .zero       (cnt_zero)
  );

  always_comb begin
    state_nx = state;
    req_nx   = pma_req;
    pwr_nx   = pma_pwr_state;
    rate_nx  = pma_rate;
    ok_nx    = pclk_change_ok;
    done_nx  = pwr_chg_done;
    err_nx   = 1'b0;
    case (state)
      ST_INIT: begin
        if (lane_startup_done) begin
          done_nx  = 1'b1;
          state_nx = ST_GAP;
        end
      end
      ST_IDLE: begin
        // A rate change absorbs any PowerDown change.
        if (pipe_rate != pma_rate) begin
          rate_nx  = pipe_rate;
          pwr_nx   = pipe_powerdown;
          req_nx   = 1'b1;
          state_nx = ST_RATE_REQ;
        end else if (pipe_powerdown != pma_pwr_state) begin
          pwr_nx   = pipe_powerdown;
          req_nx   = 1'b1;
          state_nx = ST_PWR_REQ;
        end
      end
      ST_PWR_REQ: begin
        if (pma_ack || tmo_hit) begin
          req_nx   = 1'b0;
          done_nx  = ~pwr_chg_done;
          err_nx   = !pma_ack;
          state_nx = ST_GAP;
        end
      end
      ST_RATE_REQ: begin
        if (pma_ack) begin
          req_nx   = 1'b0;
          ok_nx    = 1'b1;
          state_nx = ST_PCLK_WAIT;
        end else if (tmo_hit) begin
          req_nx   = 1'b0;
          done_nx  = ~pwr_chg_done;
          err_nx   = 1'b1;
          state_nx = ST_GAP;
        end
      end
      ST_PCLK_WAIT: begin
        if (pclk_change_ack || tmo_hit) begin
          ok_nx    = 1'b0;
          done_nx  = ~pwr_chg_done;
          err_nx   = !pclk_change_ack;
          state_nx = ST_GAP;
        end
      end
      ST_GAP: begin
        if (cnt_zero) state_nx = ST_IDLE;
      end
      default: state_nx = ST_INIT;
    endcase
  end

  always_ff @(posedge pipe_clk or negedge pipe_rst_n) begin
    if (!pipe_rst_n) begin
      state          <= ST_INIT;
      pma_req        <= 1'b0;
      pma_pwr_state  <= RST_PWR;
      pma_rate       <= RST_RATE;
      pclk_change_ok <= 1'b0;
      pwr_chg_done   <= 1'b0;
      busy           <= 1'b1;
      timeout_err    <= 1'b0;
    end else begin
      state          <= state_nx;
      pma_req        <= req_nx;
      pma_pwr_state  <= pwr_nx;
      pma_rate       <= rate_nx;
      pclk_change_ok <= ok_nx;
      pwr_chg_done   <= done_nx;
      busy           <= (state_nx != ST_IDLE);
      timeout_err    <= err_nx;
    end
  end

endmodule

// File: tb/tb_mp_pwr_rate_seq_usb4.sv
// Scoreboard bench for mp_pwr_rate_seq_usb4.
// Honours MP_PWR_SEQ_TIMEOUT_EN when defined.
module tb_mp_pwr_rate_seq_usb4;

  localparam int RW  = 2;
  localparam int MG  = 4;
  localparam int TMO = 16;

  localparam int K_INIT = 0;
  localparam int K_PWR  = 1;
  localparam int K_RATE = 2;
  localparam int K_TMO  = 3;
  localparam int K_PWNC = 4;

`ifdef MP_PWR_SEQ_TIMEOUT_EN
  localparam int EXP_ERR = 1;
`else
  localparam int EXP_ERR = 0;
`endif

  logic          pipe_clk;
  logic          pipe_rst_n;
  logic          lane_startup_done;
  logic [3:0]    pipe_powerdown;
  logic [RW-1:0] pipe_rate;
  logic          pma_ack;
  logic          pclk_change_ack;
  logic          pma_req;
  logic [3:0]    pma_pwr_state;
  logic [RW-1:0] pma_rate;
  logic          pclk_change_ok;
  logic          pwr_chg_done;
  logic          busy;
  logic          timeout_err;

  mp_pwr_rate_seq_usb4 #(
    .RATE_W  (RW),
    .MIN_GAP (MG),
    .TMO_CYC (TMO)
  ) dut (
    .pipe_clk          (pipe_clk),
    .pipe_rst_n        (pipe_rst_n),
    .lane_startup_done (lane_startup_done),
    .pipe_powerdown    (pipe_powerdown),
    .pipe_rate         (pipe_rate),
    .pma_ack           (pma_ack),
    .pclk_change_ack   (pclk_change_ack),
    .pma_req           (pma_req),
    .pma_pwr_state     (pma_pwr_state),
    .pma_rate          (pma_rate),
    .pclk_change_ok    (pclk_change_ok),
    .pwr_chg_done      (pwr_chg_done),
    .busy              (busy),
    .timeout_err       (timeout_err)
  );

  initial pipe_clk = 1'b0;
  always #5 pipe_clk = ~pipe_clk;

  typedef struct {
    logic [3:0]    pd;
    logic [RW-1:0] rate;
    int            kind;
    int            da;
    int            dc;
  } exp_t;

  exp_t q[$];
  int tests = 0;
  int fails = 0;

  logic [3:0]    cur_pd;
  logic [RW-1:0] cur_rate;
  int  pma_d  = 1;
  int  pclk_d = 1;
  bit  ack_en = 1'b1;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // PMA side: ack da cycles after req is seen, drop once req falls.
  initial begin
    pma_ack = 1'b0;
    forever begin
      @(negedge pipe_clk);
      if (pma_req && !pma_ack && ack_en) begin
        repeat (pma_d - 1) @(posedge pipe_clk);
        #1 pma_ack = 1'b1;
        do @(negedge pipe_clk); while (pma_req);
        pma_ack = 1'b0;
      end
    end
  end

  // MAC side PCLK switch.
  initial begin
    pclk_change_ack = 1'b0;
    forever begin
      @(negedge pipe_clk);
      if (pclk_change_ok && !pclk_change_ack) begin
        repeat (pclk_d - 1) @(posedge pipe_clk);
        #1 pclk_change_ack = 1'b1;
        do @(negedge pipe_clk); while (pclk_change_ok);
        pclk_change_ack = 1'b0;
      end
    end
  end

  // Monitor: each toggle of pwr_chg_done retires one expected change.
  logic prev_done = 1'b0;
  int  req_run = 0, last_req_run = 0;
  int  ok_run = 0, last_ok_run = 0;
  bit  ok_seen = 1'b0;
  int  since_tog = 0;
  bit  gap_arm = 1'b0;
  int  gap_cnt = 0;
  int  err_cnt = 0;
  bit  first_tog = 1'b1;

  always @(negedge pipe_clk) begin
    exp_t e;
    if (!pipe_rst_n) begin
      prev_done = pwr_chg_done;
    end else begin
      since_tog++;
      if (timeout_err) err_cnt++;
      if (pma_req) req_run++;
      else if (req_run != 0) begin
        last_req_run = req_run;
        req_run = 0;
      end
      if (pclk_change_ok) begin
        ok_run++;
        ok_seen = 1'b1;
      end else if (ok_run != 0) begin
        last_ok_run = ok_run;
        ok_run = 0;
      end
      if (gap_arm) begin
        gap_cnt++;
        if (!busy || gap_cnt > MG + 4) begin
          chk("gap_len", gap_cnt, MG);
          gap_arm = 1'b0;
        end
      end
      if (pwr_chg_done !== prev_done) begin
        if (q.size() == 0) begin
          chk("unexpected_toggle", 1, 0);
        end else begin
          e = q.pop_front();
          chk("tog_pwr_state", pma_pwr_state, e.pd);
          chk("tog_rate", pma_rate, e.rate);
          chk("tog_ok_low", pclk_change_ok, 0);
          chk("tog_req_low", pma_req, 0);
          if (!first_tog) chk("tog_space", since_tog >= MG, 1);
          case (e.kind)
            K_INIT: chk("first_done", pwr_chg_done, 1);
            K_PWR: begin
              chk("pwr_req_cyc", last_req_run, e.da);
              chk("pwr_no_ok", ok_seen, 0);
            end
            K_RATE: begin
              chk("rate_req_cyc", last_req_run, e.da);
              chk("ok_cyc", last_ok_run, e.dc);
            end
            K_TMO: begin
              chk("tmo_err", timeout_err, 1);
              chk("tmo_req_cyc", last_req_run, TMO);
            end
            default: chk("pwr_no_ok", ok_seen, 0);
          endcase
        end
        prev_done    = pwr_chg_done;
        first_tog    = 1'b0;
        since_tog    = 0;
        gap_arm      = 1'b1;
        gap_cnt      = 0;
        ok_seen      = 1'b0;
        last_req_run = 0;
        last_ok_run  = 0;
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge pipe_clk);
      n++;
    end while ((q.size() != 0 || busy) && n < 1000);
    if (n >= 1000) chk("idle_wait_expired", 0, 1);
  endtask

  // Reference rule: rate change dominates, otherwise PowerDown.
  task automatic issue(input logic [3:0] pd, input logic [RW-1:0] rt,
                       input int da, input int dc);
    exp_t e;
    int   k;
    k = -1;
    if (rt !== cur_rate) k = K_RATE;
    else if (pd !== cur_pd) k = K_PWR;
    pma_d  = da;
    pclk_d = dc;
    if (k >= 0) begin
      e = '{pd: pd, rate: rt, kind: k, da: da, dc: dc};
      q.push_back(e);
    end
    cur_pd = pd;
    cur_rate = rt;
    pipe_powerdown = pd;
    pipe_rate = rt;
    @(negedge pipe_clk);
    if (k >= 0) chk("req_latency", pma_req, 1);
    else chk("no_change_idle", busy, 0);
  endtask

  initial begin
    exp_t e;
    pipe_rst_n = 1'b0;
    lane_startup_done = 1'b0;
    pipe_powerdown = 4'd2;
    pipe_rate = '0;
    cur_pd = 4'd2;
    cur_rate = '0;
    repeat (2) @(negedge pipe_clk);
    chk("rst_req", pma_req, 0);
    chk("rst_pwr", pma_pwr_state, 2);
    chk("rst_rate", pma_rate, 0);
    chk("rst_ok", pclk_change_ok, 0);
    chk("rst_done", pwr_chg_done, 0);
    chk("rst_busy", busy, 1);
    chk("rst_err", timeout_err, 0);
    pipe_rst_n = 1'b1;
    repeat (4) @(negedge pipe_clk);
    chk("pre_start_done", pwr_chg_done, 0);
    chk("pre_start_busy", busy, 1);
    e = '{pd: 4'd2, rate: '0, kind: K_INIT, da: 0, dc: 0};
    q.push_back(e);
    lane_startup_done = 1'b1;
    @(negedge pipe_clk);
    chk("startup_done", pwr_chg_done, 1);
    wait_idle();
    lane_startup_done = 1'b0;

    issue(4'd0, 2'd0, 3, 1);
    wait_idle();
    issue(4'd0, 2'd1, 2, 10);
    wait_idle();
    issue(4'd1, 2'd2, 4, 3);
    wait_idle();

    // Retarget twice while the first sequence is in flight.
    issue(4'd0, 2'd2, 5, 1);
    pipe_powerdown = 4'd1;
    @(negedge pipe_clk);
    pipe_powerdown = 4'd3;
    e = '{pd: 4'd3, rate: 2'd2, kind: K_PWR, da: 5, dc: 1};
    q.push_back(e);
    cur_pd = 4'd3;
    wait_idle();

    for (int i = 0; i < 20; i++) begin
      issue(4'($urandom_range(0, 3)), RW'($urandom_range(0, 3)),
            int'($urandom_range(1, 6)), int'($urandom_range(1, 6)));
      wait_idle();
    end

    // Withheld PMA ack.
    ack_en = 1'b0;
    pma_d = 2;
    cur_pd = (cur_pd == 4'd0) ? 4'd1 : 4'd0;
`ifdef MP_PWR_SEQ_TIMEOUT_EN
    e = '{pd: cur_pd, rate: cur_rate, kind: K_TMO, da: 0, dc: 0};
    q.push_back(e);
    pipe_powerdown = cur_pd;
    wait_idle();
    ack_en = 1'b1;
`else
    e = '{pd: cur_pd, rate: cur_rate, kind: K_PWNC, da: 0, dc: 0};
    q.push_back(e);
    pipe_powerdown = cur_pd;
    repeat (100) @(negedge pipe_clk);
    chk("hold_busy", busy, 1);
    chk("hold_req", pma_req, 1);
    ack_en = 1'b1;
    wait_idle();
`endif

    chk("err_pulses", err_cnt, EXP_ERR);
    chk("queue_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    repeat (60000) @(posedge pipe_clk);
    $display("FAIL watchdog: run did not finish");
    $fatal(1, "watchdog");
  end

endmodule
